// File: rtl/baud_tick_generator.sv
// Fractional-N baud tick generator: single-cycle rxTick every (divInt + divFrac/2^FRAC_BITS)
// clocks on average, and txTick on every OVERSAMPLE-th rxTick. A new divisor takes effect only on a bit boundary.
module baud_tick_generator #(
  parameter int DIV_INT_WIDTH  = 16,
  parameter int FRAC_BITS      = 4,
  parameter int OVERSAMPLE     = 16,
  parameter int RESET_DIV_INT  = 651,
  parameter int RESET_DIV_FRAC = 1
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     run,
  input  logic                     cfgLoad,
  input  logic [DIV_INT_WIDTH-1:0] cfgDivInt,
  input  logic [FRAC_BITS-1:0]     cfgDivFrac,
  output logic                     cfgPending,
  output logic [DIV_INT_WIDTH-1:0] divIntActive,
  output logic [FRAC_BITS-1:0]     divFracActive,
  output logic                     rxTick,
  output logic                     txTick
);

  localparam int OS_W  = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int CNT_W = DIV_INT_WIDTH + 1;

  // Divisors below 2 would make ticks run back-to-back, so they saturate to 2.
  function automatic logic [DIV_INT_WIDTH-1:0] sat_div(input logic [DIV_INT_WIDTH-1:0] d);
    return (d < DIV_INT_WIDTH'(2)) ? DIV_INT_WIDTH'(2) : d;
  endfunction

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [FRAC_BITS-1:0]     acc_q, acc_d;
  logic                     extend_q, extend_d;
  logic [OS_W-1:0]          os_q, os_d;
  logic                     rx_q, rx_d;
  logic                     tx_q, tx_d;
  logic                     pend_q, pend_d;
  logic [DIV_INT_WIDTH-1:0] pendInt_q, pendInt_d;
  logic [FRAC_BITS-1:0]     pendFrac_q, pendFrac_d;
  logic [DIV_INT_WIDTH-1:0] actInt_q, actInt_d;
  logic [FRAC_BITS-1:0]     actFrac_q, actFrac_d;

  logic [CNT_W-1:0]         term;
  logic [FRAC_BITS:0]       fracSum;
  logic                     wrap, osLast, txEdge, apply;

  always_comb begin
    term    = {1'b0, sat_div(actInt_q)} + CNT_W'(extend_q) - CNT_W'(1);
    wrap    = (cnt_q >= term);
    osLast  = (os_q == OS_W'(OVERSAMPLE - 1));
    txEdge  = wrap & osLast;
    apply   = pend_q & (~run | txEdge);
    fracSum = {1'b0, acc_q} + {1'b0, actFrac_q};

    cnt_d    = cnt_q + CNT_W'(1);
    acc_d    = acc_q;
    extend_d = extend_q;
    os_d     = os_q;
    rx_d     = 1'b0;
    tx_d     = 1'b0;
    if (!run) begin
      cnt_d    = '0;
      acc_d    = '0;
      extend_d = 1'b0;
      os_d     = '0;
    end else if (wrap) begin
      cnt_d    = '0;
      acc_d    = fracSum[FRAC_BITS-1:0];
      extend_d = fracSum[FRAC_BITS];
      rx_d     = 1'b1;
      tx_d     = osLast;
      os_d     = osLast ? '0 : os_q + OS_W'(1);
    end

    pend_d     = pend_q;
    pendInt_d  = pendInt_q;
    pendFrac_d = pendFrac_q;
    actInt_d   = actInt_q;
    actFrac_d  = actFrac_q;
    // A fresh divisor restarts the fractional phase so the next bit is exact.
    if (apply) begin
      actInt_d  = pendInt_q;
      actFrac_d = pendFrac_q;
      pend_d    = 1'b0;
      acc_d     = '0;
      extend_d  = 1'b0;
    end
    if (cfgLoad) begin
      pendInt_d  = cfgDivInt;
      pendFrac_d = cfgDivFrac;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      extend_q   <= 1'b0;
      os_q       <= '0;
      rx_q       <= 1'b0;
      tx_q       <= 1'b0;
      pend_q     <= 1'b0;
      pendInt_q  <= '0;
      pendFrac_q <= '0;
      actInt_q   <= DIV_INT_WIDTH'(RESET_DIV_INT);
      actFrac_q  <= FRAC_BITS'(RESET_DIV_FRAC);
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      extend_q   <= extend_d;
      os_q       <= os_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      pend_q     <= pend_d;
      pendInt_q  <= pendInt_d;
      pendFrac_q <= pendFrac_d;
      actInt_q   <= actInt_d;
      actFrac_q  <= actFrac_d;
    end
  end

  assign rxTick        = rx_q;
  assign txTick        = tx_q;
  assign cfgPending    = pend_q;
  assign divIntActive  = actInt_q;
  assign divFracActive = actFrac_q;

endmodule
